// File: rtl/mod_clk_monitor_if.sv
// Signal bundle between the modulation clock source side and the clock monitor.
interface mod_clk_monitor_if #(
  parameter int CNT_W = 18
);
  logic             DRAIN_B;
  logic             MODL_IN;
  logic             MOD_IN;
  logic             MODN_IN;
  logic             CLR_ERR;
  logic             VALID;
  logic [CNT_W-1:0] PERIOD;
  logic [CNT_W-1:0] MOD_WIDTH;
  logic [CNT_W-1:0] MODN_WIDTH;
  logic [CNT_W-1:0] MOD_PHASE;
  logic [CNT_W-1:0] MODN_PHASE;
  logic             ARMED;
  logic             OVERLAP_ERR;
  logic             TIMEOUT_ERR;

  modport master (
    output DRAIN_B, MODL_IN, MOD_IN, MODN_IN, CLR_ERR,
    input  VALID, PERIOD, MOD_WIDTH, MODN_WIDTH, MOD_PHASE, MODN_PHASE,
           ARMED, OVERLAP_ERR, TIMEOUT_ERR
  );

  modport slave (
    input  DRAIN_B, MODL_IN, MOD_IN, MODN_IN, CLR_ERR,
    output VALID, PERIOD, MOD_WIDTH, MODN_WIDTH, MOD_PHASE, MODN_PHASE,
           ARMED, OVERLAP_ERR, TIMEOUT_ERR
  );
endinterface

// File: rtl/mod_clk_monitor.sv
// Receive-side checker for MOD / MODN / MODL: measures frame period, active
// widths and first-edge phases per MODL frame, and flags overlap and timeout.
module mod_clk_monitor #(
  parameter int CNT_W      = 18,
  parameter bit ACTIVE_LVL = 1'b0
) (
  input logic              CLK_IN,
  input logic              RST,
  mod_clk_monitor_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, MEASURE = 1'b1} state_t;

  localparam logic [CNT_W-1:0] FC_MAX = '1;
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  state_t state, state_nxt;

  logic modl_q, modl_qq, mod_q, mod_qq, modn_q, modn_qq, drain_q, clr_q;
  logic [CNT_W-1:0] fc, mod_acc, modn_acc, mod_ph, modn_ph;
  logic mod_seen, modn_seen;

  logic det, mod_act, modn_act, mod_edge, modn_edge;
  logic timeout, frame_end, overlap, run;
  logic [CNT_W-1:0] fc_inc, mod_width_now, modn_width_now;
  logic [CNT_W-1:0] mod_phase_now, modn_phase_now;

  assign det       = modl_q & ~modl_qq;
  assign mod_act   = (mod_q == ACTIVE_LVL);
  assign modn_act  = (modn_q == ACTIVE_LVL);
  assign mod_edge  = mod_act & (mod_qq != ACTIVE_LVL);
  assign modn_edge = modn_act & (modn_qq != ACTIVE_LVL);
  assign timeout   = (state == MEASURE) && (fc == FC_MAX);
  assign frame_end = (state == MEASURE) && !timeout && drain_q && det;
  assign overlap   = (state == MEASURE) && mod_act && modn_act;

  assign fc_inc         = fc + ONE;
  assign mod_width_now  = mod_acc + CNT_W'(mod_act);
  assign modn_width_now = modn_acc + CNT_W'(modn_act);
  assign mod_phase_now  = mod_seen ? mod_ph : (mod_edge ? fc_inc : '0);
  assign modn_phase_now = modn_seen ? modn_ph : (modn_edge ? fc_inc : '0);

  assign bus.ARMED = (state == MEASURE);

  // One register stage per input plus a second stage for edge detection
  always_ff @(posedge CLK_IN) begin
    if (RST) begin
      modl_q  <= 1'b0;
      modl_qq <= 1'b0;
      mod_q   <= 1'b0;
      mod_qq  <= 1'b0;
      modn_q  <= 1'b0;
      modn_qq <= 1'b0;
      drain_q <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      modl_q  <= bus.MODL_IN;
      modl_qq <= modl_q;
      mod_q   <= bus.MOD_IN;
      mod_qq  <= mod_q;
      modn_q  <= bus.MODN_IN;
      modn_qq <= modn_q;
      drain_q <= bus.DRAIN_B;
      clr_q   <= bus.CLR_ERR;
    end
  end

  // State register
  always_ff @(posedge CLK_IN) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and whether the frame counters keep running this cycle
  always_comb begin
    state_nxt = state;
    run       = 1'b0;
    case (state)
      IDLE: begin
        if (det && drain_q) state_nxt = MEASURE;
      end
      MEASURE: begin
        if (timeout || !drain_q) state_nxt = IDLE;
        else                     run       = !frame_end;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Frame counter, active-cycle accumulators and first-edge phase capture
  always_ff @(posedge CLK_IN) begin
    if (RST || !run) begin
      fc        <= '0;
      mod_acc   <= '0;
      modn_acc  <= '0;
      mod_ph    <= '0;
      modn_ph   <= '0;
      mod_seen  <= 1'b0;
      modn_seen <= 1'b0;
    end else begin
      fc       <= fc_inc;
      mod_acc  <= mod_width_now;
      modn_acc <= modn_width_now;
      if (mod_edge && !mod_seen) begin
        mod_ph   <= fc_inc;
        mod_seen <= 1'b1;
      end
      if (modn_edge && !modn_seen) begin
        modn_ph   <= fc_inc;
        modn_seen <= 1'b1;
      end
    end
  end

  // Result registers, loaded only when a complete frame closes
  always_ff @(posedge CLK_IN) begin
    if (RST) begin
      bus.VALID      <= 1'b0;
      bus.PERIOD     <= '0;
      bus.MOD_WIDTH  <= '0;
      bus.MODN_WIDTH <= '0;
      bus.MOD_PHASE  <= '0;
      bus.MODN_PHASE <= '0;
    end else begin
      bus.VALID <= frame_end;
      if (frame_end) begin
        bus.PERIOD     <= fc_inc;
        bus.MOD_WIDTH  <= mod_width_now;
        bus.MODN_WIDTH <= modn_width_now;
        bus.MOD_PHASE  <= mod_phase_now;
        bus.MODN_PHASE <= modn_phase_now;
      end
    end
  end

  // Sticky fault flags; a fresh fault outranks a same-cycle clear
  always_ff @(posedge CLK_IN) begin
    if (RST) begin
      bus.OVERLAP_ERR <= 1'b0;
      bus.TIMEOUT_ERR <= 1'b0;
    end else begin
      if (overlap)    bus.OVERLAP_ERR <= 1'b1;
      else if (clr_q) bus.OVERLAP_ERR <= 1'b0;
      if (timeout)    bus.TIMEOUT_ERR <= 1'b1;
      else if (clr_q) bus.TIMEOUT_ERR <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mod_clk_monitor.sv
// Testbench for mod_clk_monitor: frame-level reference model plus directed
// and randomized MODL/MOD/MODN patterns.
module tb_mod_clk_monitor;

  localparam int CNT_W      = 8;
  localparam bit ACTIVE_LVL = 1'b0;
  localparam int FC_MAX     = (1 << CNT_W) - 1;

  logic CLK_IN = 1'b0;
  logic RST    = 1'b1;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state: frame sample lists and the expected outputs
  bit q_modl, q_mod, q_modn, q_drain, q_clr, qq_modl;
  bit m_armed, m_valid, m_ov, m_to;
  int m_period, m_mw, m_nw, m_mp, m_np;
  int m_valid_cnt;
  bit mq[$];
  bit nq[$];

  int saved_cnt;

  mod_clk_monitor_if #(.CNT_W(CNT_W)) bus ();

  mod_clk_monitor #(.CNT_W(CNT_W), .ACTIVE_LVL(ACTIVE_LVL)) dut (
    .CLK_IN (CLK_IN),
    .RST    (RST),
    .bus    (bus)
  );

  // Free-running clock
  always #5 CLK_IN = ~CLK_IN;

  function automatic bit act(input bit b);
    return b == ACTIVE_LVL;
  endfunction

  // Width and first active-going edge of one frame; element 0 is the sample
  // just before the frame, elements 1..N are the frame itself
  function automatic void summarize(input bit s[$], output int width, output int phase);
    width = 0;
    phase = 0;
    for (int i = 1; i < s.size(); i++) begin
      if (act(s[i])) width++;
      if (phase == 0 && act(s[i]) && !act(s[i-1])) phase = i;
    end
  endfunction

  task automatic check_output(input string name, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs the DUT samples now
  task automatic model_step();
    bit det, ov_set, to_set;
    int n;
    if (RST) begin
      q_modl = 0; q_mod = 0; q_modn = 0; q_drain = 0; q_clr = 0; qq_modl = 0;
      m_armed = 0; m_valid = 0; m_ov = 0; m_to = 0;
      m_period = 0; m_mw = 0; m_nw = 0; m_mp = 0; m_np = 0;
      mq.delete();
      nq.delete();
      return;
    end
    det     = q_modl && !qq_modl;
    n       = mq.size() - 1;
    m_valid = 0;
    ov_set  = m_armed && act(q_mod) && act(q_modn);
    to_set  = m_armed && (n == FC_MAX);
    if (m_armed) begin
      if (to_set || !q_drain) begin
        m_armed = 0;
      end else begin
        mq.push_back(q_mod);
        nq.push_back(q_modn);
        if (det) begin
          m_period = mq.size() - 1;
          summarize(mq, m_mw, m_mp);
          summarize(nq, m_nw, m_np);
          m_valid = 1;
          m_valid_cnt++;
          mq = '{q_mod};
          nq = '{q_modn};
        end
      end
    end else if (det && q_drain) begin
      m_armed = 1;
      mq = '{q_mod};
      nq = '{q_modn};
    end
    if (ov_set)     m_ov = 1;
    else if (q_clr) m_ov = 0;
    if (to_set)     m_to = 1;
    else if (q_clr) m_to = 0;
    qq_modl = q_modl;
    q_modl  = bus.MODL_IN;
    q_mod   = bus.MOD_IN;
    q_modn  = bus.MODN_IN;
    q_drain = bus.DRAIN_B;
    q_clr   = bus.CLR_ERR;
  endtask

  // Model update on every rising edge, full output compare on the falling edge
  initial begin
    forever begin
      @(posedge CLK_IN);
      model_step();
      @(negedge CLK_IN);
      check_output("VALID",       int'(bus.VALID),       int'(m_valid));
      check_output("ARMED",       int'(bus.ARMED),       int'(m_armed));
      check_output("OVERLAP_ERR", int'(bus.OVERLAP_ERR), int'(m_ov));
      check_output("TIMEOUT_ERR", int'(bus.TIMEOUT_ERR), int'(m_to));
      check_output("PERIOD",      int'(bus.PERIOD),      m_period);
      check_output("MOD_WIDTH",   int'(bus.MOD_WIDTH),   m_mw);
      check_output("MODN_WIDTH",  int'(bus.MODN_WIDTH),  m_nw);
      check_output("MOD_PHASE",   int'(bus.MOD_PHASE),   m_mp);
      check_output("MODN_PHASE",  int'(bus.MODN_PHASE),  m_np);
    end
  end

  task automatic drive_cycle(input bit modl, input bit mod, input bit modn,
                             input bit drain, input bit clr);
    @(negedge CLK_IN);
    bus.MODL_IN = modl;
    bus.MOD_IN  = mod;
    bus.MODN_IN = modn;
    bus.DRAIN_B = drain;
    bus.CLR_ERR = clr;
  endtask

  function automatic bit win(input int c, input int start, input int len);
    return (c >= start && c < start + len) ? ACTIVE_LVL : !ACTIVE_LVL;
  endfunction

  // Drive nframes MODL frames; CLR_ERR pulse and 4-cycle drain apply to frame 0
  task automatic apply_stimulus(input int period, input int ms, input int ml,
                                input int ns, input int nl, input int nframes,
                                input int clr_at, input int drain_at);
    for (int f = 0; f < nframes; f++) begin
      for (int c = 0; c < period; c++) begin
        drive_cycle(c < period / 2, win(c, ms, ml), win(c, ns, nl),
                    !(f == 0 && drain_at >= 0 && c >= drain_at && c < drain_at + 4),
                    f == 0 && c == clr_at);
      end
    end
  endtask

  // Pin the nominal frame results with hand-computed values
  task automatic check_nominal(input string tag);
    check_output({tag, " PERIOD"},     int'(bus.PERIOD),     32);
    check_output({tag, " MOD_WIDTH"},  int'(bus.MOD_WIDTH),  5);
    check_output({tag, " MOD_PHASE"},  int'(bus.MOD_PHASE),  10);
    check_output({tag, " MODN_WIDTH"}, int'(bus.MODN_WIDTH), 5);
    check_output({tag, " MODN_PHASE"}, int'(bus.MODN_PHASE), 26);
  endtask

  // Directed scenarios followed by randomized frames
  initial begin
    int per, ms, ml, ns, nl, ca, da;
    bus.MODL_IN = 1'b0;
    bus.MOD_IN  = !ACTIVE_LVL;
    bus.MODN_IN = !ACTIVE_LVL;
    bus.DRAIN_B = 1'b1;
    bus.CLR_ERR = 1'b0;

    repeat (3) drive_cycle(0, !ACTIVE_LVL, !ACTIVE_LVL, 1, 0);
    check_output("reset PERIOD", int'(bus.PERIOD), 0);
    check_output("reset ARMED",  int'(bus.ARMED),  0);
    check_output("reset VALID",  int'(bus.VALID),  0);
    RST = 1'b0;

    // Nominal frames
    apply_stimulus(32, 10, 5, 26, 5, 4, -1, -1);
    check_nominal("nominal");
    check_output("nominal valid count", m_valid_cnt, 3);
    check_output("nominal OVERLAP_ERR", int'(bus.OVERLAP_ERR), 0);
    check_output("nominal ARMED", int'(bus.ARMED), 1);

    // Reset for 3 cycles while MODL is low in the middle of a frame
    for (int c = 0; c < 32; c++) begin
      drive_cycle(c < 16, win(c, 10, 5), win(c, 26, 5), 1, 0);
      RST = (c >= 20 && c < 23);
      if (c == 23) begin
        check_output("midreset PERIOD",    int'(bus.PERIOD),    0);
        check_output("midreset MOD_WIDTH", int'(bus.MOD_WIDTH), 0);
        check_output("midreset ARMED",     int'(bus.ARMED),     0);
      end
    end
    saved_cnt = m_valid_cnt;
    apply_stimulus(32, 10, 5, 26, 5, 1, -1, -1);
    check_output("rearm no VALID", m_valid_cnt, saved_cnt);
    apply_stimulus(32, 10, 5, 26, 5, 2, -1, -1);
    check_output("post-reset valid count", m_valid_cnt, saved_cnt + 2);
    check_nominal("post-reset");

    // Overlap detection, stickiness and clearing
    apply_stimulus(32, 10, 5, 13, 5, 3, -1, -1);
    check_output("overlap set", int'(bus.OVERLAP_ERR), 1);
    apply_stimulus(32, 10, 5, 26, 5, 2, -1, -1);
    check_output("overlap sticky", int'(bus.OVERLAP_ERR), 1);
    apply_stimulus(32, 10, 5, 26, 5, 1, 20, -1);
    check_output("overlap cleared", int'(bus.OVERLAP_ERR), 0);
    apply_stimulus(32, 10, 5, 13, 5, 1, 14, -1);
    check_output("overlap set beats clear", int'(bus.OVERLAP_ERR), 1);
    apply_stimulus(32, 10, 5, 26, 5, 1, 20, -1);
    check_output("overlap cleared again", int'(bus.OVERLAP_ERR), 0);

    // Modulation clock held inactive for whole frames
    apply_stimulus(32, 10, 0, 26, 5, 3, -1, -1);
    check_output("idle MOD width", int'(bus.MOD_WIDTH), 0);
    check_output("idle MOD phase", int'(bus.MOD_PHASE), 0);
    check_output("idle MOD MODN width", int'(bus.MODN_WIDTH), 5);
    check_output("idle MOD MODN phase", int'(bus.MODN_PHASE), 26);
    check_output("idle MOD PERIOD", int'(bus.PERIOD), 32);

    // Drain in the middle of a frame
    apply_stimulus(32, 10, 5, 26, 5, 2, -1, -1);
    apply_stimulus(32, 10, 5, 26, 5, 1, -1, 16);
    check_output("drain ARMED", int'(bus.ARMED), 0);
    saved_cnt = m_valid_cnt;
    apply_stimulus(32, 10, 5, 26, 5, 1, -1, -1);
    check_output("drain rearm ARMED", int'(bus.ARMED), 1);
    check_output("drain rearm no VALID", m_valid_cnt, saved_cnt);
    apply_stimulus(32, 10, 5, 26, 5, 1, -1, -1);
    check_output("drain first VALID", m_valid_cnt, saved_cnt + 1);
    check_nominal("post-drain");

    // Timeout: one MODL rise and then MODL held low
    apply_stimulus(32, 10, 5, 26, 5, 2, -1, -1);
    repeat (16) drive_cycle(1, !ACTIVE_LVL, !ACTIVE_LVL, 1, 0);
    saved_cnt = m_valid_cnt;
    repeat (300) drive_cycle(0, !ACTIVE_LVL, !ACTIVE_LVL, 1, 0);
    check_output("timeout flag", int'(bus.TIMEOUT_ERR), 1);
    check_output("timeout ARMED", int'(bus.ARMED), 0);
    check_output("timeout no VALID", m_valid_cnt, saved_cnt);
    check_nominal("timeout hold");
    drive_cycle(0, !ACTIVE_LVL, !ACTIVE_LVL, 1, 1);
    repeat (3) drive_cycle(0, !ACTIVE_LVL, !ACTIVE_LVL, 1, 0);
    check_output("timeout cleared", int'(bus.TIMEOUT_ERR), 0);

    // Randomized frames with occasional clears and drains
    for (int f = 0; f < 40; f++) begin
      per = $urandom_range(6, 50);
      ms  = $urandom_range(0, per - 1);
      ml  = $urandom_range(0, per - ms);
      ns  = $urandom_range(0, per - 1);
      nl  = $urandom_range(0, per - ns);
      ca  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, per - 1)) : -1;
      da  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, per - 1)) : -1;
      apply_stimulus(per, ms, ml, ns, nl, 1, ca, da);
    end
    repeat (4) drive_cycle(0, !ACTIVE_LVL, !ACTIVE_LVL, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
